// File: rtl/pe_scratch_seq.sv
// Address/strobe sequencer for one PE's IF, filter and PSUM scratchpads (one 1-D conv row per command).
// Optional macro PSUM_ACC_EN: when defined, write-back is read-modify-write (psum_acc_sel=1 in WB).
module pe_scratch_seq #(
  parameter int ADDR_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] cfg_filt_len,
  input  logic [ADDR_LEN-1:0] cfg_num_out,
  input  logic [ADDR_LEN-1:0] cfg_stride,
  input  logic [ADDR_LEN-1:0] cfg_if_base,
  output logic                busy,
  output logic                done,
  output logic                filt_ren,
  output logic [ADDR_LEN-1:0] filt_raddr,
  output logic                filt_clr,
  output logic [ADDR_LEN-1:0] if_raddr,
  output logic                mac_en,
  output logic                mac_clr,
  output logic [ADDR_LEN-1:0] psum_raddr,
  output logic [ADDR_LEN-1:0] psum_waddr,
  output logic                psum_wen,
  output logic                psum_acc_sel
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_LAST = 3'd2,
    S_WB   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_LEN-1:0] ONE = ADDR_LEN'(1);

  state_t              state_q, state_d;
  logic [ADDR_LEN-1:0] k_q, k_d;
  logic [ADDR_LEN-1:0] o_q, o_d;
  logic [ADDR_LEN-1:0] win_q, win_d;
  logic [ADDR_LEN-1:0] filt_len_q, filt_len_d;
  logic [ADDR_LEN-1:0] num_out_q, num_out_d;
  logic [ADDR_LEN-1:0] stride_q, stride_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                filt_ren_q, filt_ren_d;
  logic [ADDR_LEN-1:0] filt_raddr_q, filt_raddr_d;
  logic                filt_clr_q, filt_clr_d;
  logic [ADDR_LEN-1:0] if_raddr_q, if_raddr_d;
  logic                mac_en_q, mac_en_d;
  logic                mac_clr_q, mac_clr_d;
  logic [ADDR_LEN-1:0] psum_raddr_q, psum_raddr_d;
  logic [ADDR_LEN-1:0] psum_waddr_q, psum_waddr_d;
  logic                psum_wen_q, psum_wen_d;

  // State, loop counters and latched command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      o_q        <= '0;
      win_q      <= '0;
      filt_len_q <= '0;
      num_out_q  <= '0;
      stride_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      o_q        <= o_d;
      win_q      <= win_d;
      filt_len_q <= filt_len_d;
      num_out_q  <= num_out_d;
      stride_q   <= stride_d;
    end
  end

  // Next-state and loop-index logic; address sums wrap naturally at ADDR_LEN bits
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    o_d        = o_q;
    win_d      = win_q;
    filt_len_d = filt_len_q;
    num_out_d  = num_out_q;
    stride_d   = stride_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((cfg_filt_len != '0) && (cfg_num_out != '0)) begin
            filt_len_d = cfg_filt_len;
            num_out_d  = cfg_num_out;
            stride_d   = cfg_stride;
            win_d      = cfg_if_base;
            k_d        = '0;
            o_d        = '0;
            state_d    = S_RUN;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_RUN: begin
        k_d = k_q + ONE;
        if (k_q == (filt_len_q - ONE)) begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        state_d = S_WB;
      end
      S_WB: begin
        if (o_q == (num_out_q - ONE)) begin
          state_d = S_FIN;
        end else begin
          o_d     = o_q + ONE;
          win_d   = win_q + stride_q;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so every output is a flop.
  // The IF address and MAC strobes trail the filter read by one cycle to meet its registered dout.
  always_comb begin
    busy_d       = (state_d == S_RUN) || (state_d == S_LAST) || (state_d == S_WB);
    done_d       = (state_d == S_FIN);
    filt_ren_d   = (state_d == S_RUN);
    filt_raddr_d = filt_ren_d ? k_d : filt_raddr_q;
    filt_clr_d   = (state_q == S_IDLE) && (state_d == S_RUN);
    mac_en_d     = filt_ren_q;
    mac_clr_d    = filt_ren_q && (k_q == '0);
    if_raddr_d   = filt_ren_q ? (win_q + k_q) : if_raddr_q;
    psum_raddr_d = busy_d ? o_d : psum_raddr_q;
    psum_wen_d   = (state_d == S_WB);
    psum_waddr_d = psum_wen_d ? o_d : psum_waddr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      filt_ren_q   <= 1'b0;
      filt_raddr_q <= '0;
      filt_clr_q   <= 1'b0;
      if_raddr_q   <= '0;
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      psum_raddr_q <= '0;
      psum_waddr_q <= '0;
      psum_wen_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      filt_ren_q   <= filt_ren_d;
      filt_raddr_q <= filt_raddr_d;
      filt_clr_q   <= filt_clr_d;
      if_raddr_q   <= if_raddr_d;
      mac_en_q     <= mac_en_d;
      mac_clr_q    <= mac_clr_d;
      psum_raddr_q <= psum_raddr_d;
      psum_waddr_q <= psum_waddr_d;
      psum_wen_q   <= psum_wen_d;
    end
  end

`ifdef PSUM_ACC_EN
  logic psum_acc_sel_q, psum_acc_sel_d;

  always_comb begin
    psum_acc_sel_d = (state_d == S_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_acc_sel_q <= 1'b0;
    end else begin
      psum_acc_sel_q <= psum_acc_sel_d;
    end
  end

  assign psum_acc_sel = psum_acc_sel_q;
`else
  assign psum_acc_sel = 1'b0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign filt_ren   = filt_ren_q;
  assign filt_raddr = filt_raddr_q;
  assign filt_clr   = filt_clr_q;
  assign if_raddr   = if_raddr_q;
  assign mac_en     = mac_en_q;
  assign mac_clr    = mac_clr_q;
  assign psum_raddr = psum_raddr_q;
  assign psum_waddr = psum_waddr_q;
  assign psum_wen   = psum_wen_q;

endmodule
